dll_rx_ack_gen: RTL and testbench
=================================

# dll_rx_ack_gen

Receive-side data link layer checker paired with the transmit replay buffer. Accepts framed TLPs as 16-bit words, checks the 32-bit LCRC and the 12-bit sequence number, forwards the payload to the transaction layer with a commit or drop verdict, and returns ACK/NAK DLLPs to the link partner's replay buffer. Sits between the physical-layer deframer and the receive transaction layer.

## Interface
- SEQ_W, 12, sequence number width
- DW, 16, datapath word width

- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- rx_valid  input  1  rx_data/rx_sop/rx_eop valid this cycle
- rx_sop  input  1  first word of frame: {4'b0000, seq[11:0]}
- rx_eop  input  1  last word of frame (LCRC[15:0])
- rx_data  input  16  frame word; order is seq word, payload words, LCRC[31:16], LCRC[15:0]
- tl_valid  output  1  payload word valid
- tl_data  output  16  payload word (seq and LCRC words stripped)
- tl_commit  output  1  one-cycle pulse: buffered TLP is good
- tl_drop  output  1  one-cycle pulse: buffered TLP must be discarded
- ack_valid  output  1  ACK/NAK request pending
- ack_ready  input  1  DLLP transmitter accepts request
- ack_nack  output  2  01 = ACK, 10 = NAK, 00 = none
- ack_seq  output  12  AckNak_Seq_Num

## Operation
- LCRC: polynomial 0x04C11DB7, init 0xFFFFFFFF, MSB-first, 16 bits per word, covering the seq word and all payload words. Transmitted LCRC = bitwise complement of the final CRC. Compare is exact over 32 bits.
- A 2-word delay line holds the most recent words, so the two LCRC words are never fed into the CRC or forwarded on tl_data. Payload words are emitted on tl_valid as they leave the delay line.
- State: next_rcv_seq (12-bit, resets to 0) and nak_sched (resets to 0).
- FSM states:
  - IDLE: on rx_valid & rx_sop, latch seq[11:0] and go to RECV.
  - RECV: on rx_valid & rx_eop, go to CHECK.
  - CHECK: single cycle. Evaluate the verdict, then return to IDLE.
- A new rx_sop while in RECV aborts the current frame: tl_drop pulses, no ACK/NAK is generated, and a new frame starts.
- rx_eop while in IDLE is ignored.
- Frames shorter than 3 words are treated as LCRC failures.
- Verdict in CHECK, with d = (seq - next_rcv_seq) mod 4096:
  - LCRC bad: tl_drop. If nak_sched=0, queue NAK with ack_seq = next_rcv_seq-1 and set nak_sched.
  - LCRC good, d=0: tl_commit, next_rcv_seq += 1 (wraps 4095 to 0), clear nak_sched, queue ACK with ack_seq = seq.
  - LCRC good, d >= 2048 (duplicate): tl_drop, queue ACK with ack_seq = next_rcv_seq-1.
  - LCRC good, 1 <= d < 2048 (lost TLP): tl_drop. If nak_sched=0, queue NAK with ack_seq = next_rcv_seq-1 and set nak_sched.
- ACK/NAK handshake:
  - ack_valid, ack_nack and ack_seq are held stable until ack_valid & ack_ready.
  - A new request queued while one is pending overwrites it, but a pending NAK is never replaced by an ACK.
  - Acceptance and a new queue in the same cycle: the new request wins and ack_valid stays 1.
- rx_valid low mid-frame stalls the frame. The FSM, CRC and delay line hold.

## Timing
- Reset values: all outputs 0, FSM in IDLE, next_rcv_seq=0, nak_sched=0, CRC=0xFFFFFFFF, delay line empty.
- Reset mid-frame discards the frame with no tl_drop pulse.
- tl_data lags rx_data by exactly two accepted words.
- rx_eop accepted in cycle T: CHECK occurs at T+1, and tl_commit/tl_drop pulse in cycle T+1.
- ack_valid rises at T+2 at the earliest.
- Back-to-back frames are allowed: rx_sop may arrive in cycle T+1 and is accepted while the FSM is in CHECK.
- The receiver never backpressures. There is no rx_ready.

## Test plan
- Good TLP, seq=0, payload 0x1234, 0xABCD, correct LCRC -> tl_data 0x1234, 0xABCD; tl_commit; ACK with ack_seq=0; next_rcv_seq=1.
- Same frame with LCRC bit 0 flipped -> tl_drop; NAK with ack_seq=0xFFF. A second bad frame -> tl_drop, no new NAK. Then a good seq=0 frame -> ACK 0, nak_sched cleared.
- After seq 0 and 1 accepted, resend seq=1 -> tl_drop; ACK with ack_seq=1.
- With next_rcv_seq=0x005, send good seq=0x007 -> NAK with ack_seq=0x004.
- Wrap-around: next_rcv_seq=0xFFF, good frame seq=0xFFF -> ACK 0xFFF, next_rcv_seq=0x000.
- Hold ack_ready=0 across a NAK followed by a good ACK-worthy frame -> NAK stays on ack_nack. Assert reset_n low mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/dll_rx_ack_gen.sv
// -----------------------------------------------------------------------------
// dll_rx_ack_gen
//
// Receive-side data link layer checker. Takes framed TLPs from the deframer as
// 16-bit words (seq word, payload words, LCRC[31:16], LCRC[15:0]), checks the
// LCRC and the sequence number, streams the payload to the transaction layer
// and follows it with a commit or drop verdict, and raises ACK/NAK requests
// toward the DLLP transmitter.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   rx_valid   rx_sop/rx_eop/rx_data valid this cycle (never backpressured)
//   rx_sop     first word of a frame, carries {4'b0000, seq[11:0]}
//   rx_eop     last word of a frame, carries LCRC[15:0]
//   rx_data    frame word
//   tl_valid   payload word valid (seq and LCRC words are stripped)
//   tl_data    payload word
//   tl_commit  one-cycle pulse: buffered TLP is good
//   tl_drop    one-cycle pulse: buffered TLP must be discarded
//   ack_valid  ACK/NAK request pending
//   ack_ready  DLLP transmitter accepts the pending request
//   ack_nack   01 = ACK, 10 = NAK, 00 = none
//   ack_seq    AckNak_Seq_Num
//
// The LCRC is carried as two datapath words, so the LCRC compare assumes
// DW = 16.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// S_IDLE  | waiting for rx_sop; stray rx_eop is ignored
// S_RECV  | inside a frame, shifting words through the delay line
// S_CHECK | one cycle: verdict, sequence update, ACK/NAK queue
// -----------------------------------------------------------------------------
module dll_rx_ack_gen #(
    parameter int SEQ_W = 12,
    parameter int DW    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rx_valid,
    input  logic             rx_sop,
    input  logic             rx_eop,
    input  logic [DW-1:0]    rx_data,
    output logic             tl_valid,
    output logic [DW-1:0]    tl_data,
    output logic             tl_commit,
    output logic             tl_drop,
    output logic             ack_valid,
    input  logic             ack_ready,
    output logic [1:0]       ack_nack,
    output logic [SEQ_W-1:0] ack_seq
);

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    localparam logic [1:0] NACK_NONE = 2'b00;
    localparam logic [1:0] NACK_ACK  = 2'b01;
    localparam logic [1:0] NACK_NAK  = 2'b10;

    localparam logic [SEQ_W-1:0] SEQ_ONE = {{(SEQ_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Frame capture
    logic [SEQ_W-1:0] seq_q;
    logic [DW-1:0]    dly0_q;      // newest word
    logic [DW-1:0]    dly1_q;      // older word, next to leave
    logic [1:0]       cnt_q;       // words in frame, saturates at 3
    logic [31:0]      crc_q;
    logic             abort_q;

    // Link state
    logic [SEQ_W-1:0] next_rcv_seq_q, next_rcv_seq_d;
    logic             nak_sched_q, nak_sched_d;

    // Verdict / ACK-NAK request
    logic             lcrc_ok;
    logic [SEQ_W-1:0] seq_dist;
    logic             chk_drop;
    logic             q_req;
    logic [1:0]       q_nack;
    logic [SEQ_W-1:0] q_seq;

    logic frame_start;
    logic frame_word;
    logic frame_abort;

    // MSB-first CRC-32 over one datapath word.
    function automatic logic [31:0] crc_step(input logic [31:0] crc_in,
                                             input logic [DW-1:0] word);
        logic [31:0] c;
        logic        fb;
        c = crc_in;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = c[31] ^ word[i];
            c  = {c[30:0], 1'b0};
            if (fb) begin
                c = c ^ CRC_POLY;
            end
        end
        return c;
    endfunction

    // rx_sop is honoured in every state: it opens a frame from IDLE, follows
    // a frame back-to-back out of CHECK, and aborts an open frame in RECV.
    assign frame_start = rx_valid & rx_sop;
    assign frame_word  = rx_valid & ~rx_sop & (state_q == S_RECV);
    assign frame_abort = frame_start & (state_q == S_RECV);

    // Only the seq word and payload words have passed through the CRC once
    // rx_eop is in; the delay line then holds exactly the received LCRC.
    assign lcrc_ok  = (cnt_q == 2'd3) && ({dly1_q, dly0_q} == ~crc_q);
    assign seq_dist = seq_q - next_rcv_seq_q;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state, verdict and ACK/NAK request
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        tl_commit      = 1'b0;
        chk_drop       = 1'b0;
        q_req          = 1'b0;
        q_nack         = NACK_NONE;
        q_seq          = '0;
        next_rcv_seq_d = next_rcv_seq_q;
        nak_sched_d    = nak_sched_q;

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d = rx_eop ? S_CHECK : S_RECV;
                end
            end

            S_RECV: begin
                if (frame_start) begin
                    state_d = rx_eop ? S_CHECK : S_RECV;
                end else if (frame_word && rx_eop) begin
                    state_d = S_CHECK;
                end
            end

            S_CHECK: begin
                if (frame_start) begin
                    state_d = rx_eop ? S_CHECK : S_RECV;
                end else begin
                    state_d = S_IDLE;
                end

                if (!lcrc_ok) begin
                    chk_drop = 1'b1;
                    if (!nak_sched_q) begin
                        q_req       = 1'b1;
                        q_nack      = NACK_NAK;
                        q_seq       = next_rcv_seq_q - SEQ_ONE;
                        nak_sched_d = 1'b1;
                    end
                end else if (seq_dist == '0) begin
                    tl_commit      = 1'b1;
                    next_rcv_seq_d = next_rcv_seq_q + SEQ_ONE;
                    nak_sched_d    = 1'b0;
                    q_req          = 1'b1;
                    q_nack         = NACK_ACK;
                    q_seq          = seq_q;
                end else if (seq_dist[SEQ_W-1]) begin
                    // Behind the expected number: a replayed duplicate.
                    chk_drop = 1'b1;
                    q_req    = 1'b1;
                    q_nack   = NACK_ACK;
                    q_seq    = next_rcv_seq_q - SEQ_ONE;
                end else begin
                    // Ahead of the expected number: something was lost.
                    chk_drop = 1'b1;
                    if (!nak_sched_q) begin
                        q_req       = 1'b1;
                        q_nack      = NACK_NAK;
                        q_seq       = next_rcv_seq_q - SEQ_ONE;
                        nak_sched_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Abort pulses one cycle after the interrupting rx_sop so that tl_drop
    // stays a pure register/FSM output.
    assign tl_drop = chk_drop | abort_q;

    // ------------------------------------------------------------------
    // Delay line, word count, CRC and payload output
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seq_q    <= '0;
            dly0_q   <= '0;
            dly1_q   <= '0;
            cnt_q    <= 2'd0;
            crc_q    <= CRC_INIT;
            abort_q  <= 1'b0;
            tl_valid <= 1'b0;
            tl_data  <= '0;
        end else begin
            abort_q  <= frame_abort;
            tl_valid <= 1'b0;
            if (frame_start) begin
                seq_q  <= rx_data[SEQ_W-1:0];
                dly0_q <= rx_data;
                dly1_q <= '0;
                cnt_q  <= 2'd1;
                crc_q  <= CRC_INIT;
            end else if (frame_word) begin
                dly0_q <= rx_data;
                dly1_q <= dly0_q;
                if (cnt_q != 2'd3) begin
                    cnt_q <= cnt_q + 2'd1;
                end
                // With two words already held, the older one leaves the
                // delay line: it is covered by the CRC, and it is payload
                // unless it is the seq word (count still 2).
                if (cnt_q >= 2'd2) begin
                    crc_q <= crc_step(crc_q, dly1_q);
                end
                if (cnt_q == 2'd3) begin
                    tl_valid <= 1'b1;
                    tl_data  <= dly1_q;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Receive sequence tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_rcv_seq_q <= '0;
            nak_sched_q    <= 1'b0;
        end else begin
            next_rcv_seq_q <= next_rcv_seq_d;
            nak_sched_q    <= nak_sched_d;
        end
    end

    // ------------------------------------------------------------------
    // ACK/NAK request register
    // ------------------------------------------------------------------
    logic ack_take;
    logic nak_held;
    logic q_blocked;

    assign ack_take  = ack_valid & ack_ready;
    // A NAK that is not leaving this cycle must not be displaced by an ACK.
    assign nak_held  = ack_valid & ~ack_ready & (ack_nack == NACK_NAK);
    assign q_blocked = nak_held & (q_nack == NACK_ACK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ack_valid <= 1'b0;
            ack_nack  <= NACK_NONE;
            ack_seq   <= '0;
        end else begin
            if (q_req && !q_blocked) begin
                ack_valid <= 1'b1;
                ack_nack  <= q_nack;
                ack_seq   <= q_seq;
            end else if (ack_take) begin
                ack_valid <= 1'b0;
                ack_nack  <= NACK_NONE;
            end
        end
    end

endmodule

// File: tb/tb_dll_rx_ack_gen.sv
module tb_dll_rx_ack_gen;

    logic        clk;
    logic        reset_n;
    logic        rx_valid;
    logic        rx_sop;
    logic        rx_eop;
    logic [15:0] rx_data;
    logic        tl_valid;
    logic [15:0] tl_data;
    logic        tl_commit;
    logic        tl_drop;
    logic        ack_valid;
    logic        ack_ready;
    logic [1:0]  ack_nack;
    logic [11:0] ack_seq;

    dll_rx_ack_gen #(.SEQ_W(12), .DW(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_valid  (rx_valid),
        .rx_sop    (rx_sop),
        .rx_eop    (rx_eop),
        .rx_data   (rx_data),
        .tl_valid  (tl_valid),
        .tl_data   (tl_data),
        .tl_commit (tl_commit),
        .tl_drop   (tl_drop),
        .ack_valid (ack_valid),
        .ack_ready (ack_ready),
        .ack_nack  (ack_nack),
        .ack_seq   (ack_seq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Observed activity, sampled on the falling edge.
    logic [15:0] tl_q[$];
    int          n_commit = 0;
    int          n_drop   = 0;
    int          n_ack    = 0;
    logic [1:0]  last_nack = 2'b00;
    logic [11:0] last_seq  = 12'h000;

    always @(negedge clk) begin
        if (reset_n) begin
            if (tl_valid) tl_q.push_back(tl_data);
            if (tl_commit) n_commit++;
            if (tl_drop) n_drop++;
            if (ack_valid && ack_ready) begin
                n_ack++;
                last_nack = ack_nack;
                last_seq  = ack_seq;
            end
        end
    end

    // Expected totals, maintained by hand step by step.
    int exp_commit = 0;
    int exp_drop   = 0;
    int exp_ack    = 0;

    logic [15:0] fw[$];
    logic        commit_t1;
    logic        drop_t1;
    logic        ackv_t1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    function automatic logic [31:0] crc_word(input logic [31:0] c_in, input logic [15:0] w);
        logic [31:0] c;
        c = c_in ^ {w, 16'h0000};
        for (int b = 0; b < 16; b++) begin
            if (c[31]) c = (c << 1) ^ 32'h04C11DB7;
            else       c = c << 1;
        end
        return c;
    endfunction

    task automatic build(input logic [11:0] seq, input int npay,
                         input logic [15:0] p0, input logic [15:0] p1, input bit corrupt);
        logic [31:0] c;
        logic [31:0] l;
        fw.delete();
        fw.push_back({4'h0, seq});
        if (npay > 0) fw.push_back(p0);
        if (npay > 1) fw.push_back(p1);
        c = 32'hFFFFFFFF;
        foreach (fw[k]) c = crc_word(c, fw[k]);
        l = ~c;
        if (corrupt) l[0] = ~l[0];
        fw.push_back(l[31:16]);
        fw.push_back(l[15:0]);
    endtask

    // Drives fw; returns in the cycle after rx_eop is accepted.
    task automatic send_fw(input bit stall, input bit chk_lag);
        for (int i = 0; i < fw.size(); i++) begin
            rx_valid = 1'b1;
            rx_sop   = (i == 0);
            rx_eop   = (i == fw.size() - 1);
            rx_data  = fw[i];
            tick();
            if (chk_lag && i >= 3) begin
                chk("lag_valid", {31'd0, tl_valid}, 32'd1);
                chk("lag_data", {16'd0, tl_data}, {16'd0, fw[i-2]});
            end
            if (stall && i < fw.size() - 1) begin
                rx_valid = 1'b0;
                rx_data  = 16'hDEAD;
                tick();
            end
        end
        rx_valid  = 1'b0;
        rx_sop    = 1'b0;
        rx_eop    = 1'b0;
        commit_t1 = tl_commit;
        drop_t1   = tl_drop;
        ackv_t1   = ack_valid;
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_commits"}, n_commit, exp_commit);
        chk({tag, "_drops"}, n_drop, exp_drop);
        chk({tag, "_acks"}, n_ack, exp_ack);
    endtask

    task automatic chk_last(input string tag, input logic [1:0] nack, input logic [11:0] seq);
        chk({tag, "_nack"}, {30'd0, last_nack}, {30'd0, nack});
        chk({tag, "_seq"}, {20'd0, last_seq}, {20'd0, seq});
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        settle(2);
        reset_n = 1'b1;
        settle(1);
    endtask

    initial begin
        reset_n   = 1'b0;
        rx_valid  = 1'b0;
        rx_sop    = 1'b0;
        rx_eop    = 1'b0;
        rx_data   = 16'h0000;
        ack_ready = 1'b1;
        settle(2);

        // Reset state
        chk("rst_tl_valid", {31'd0, tl_valid}, 32'd0);
        chk("rst_tl_data", {16'd0, tl_data}, 32'd0);
        chk("rst_commit", {31'd0, tl_commit}, 32'd0);
        chk("rst_drop", {31'd0, tl_drop}, 32'd0);
        chk("rst_ack_valid", {31'd0, ack_valid}, 32'd0);
        chk("rst_ack_nack", {30'd0, ack_nack}, 32'd0);
        chk("rst_ack_seq", {20'd0, ack_seq}, 32'd0);
        reset_n = 1'b1;
        settle(1);

        // Good TLP seq 0
        tl_q.delete();
        build(12'h000, 2, 16'h1234, 16'hABCD, 1'b0);
        send_fw(1'b0, 1'b1);
        chk("a_commit_t1", {31'd0, commit_t1}, 32'd1);
        chk("a_drop_t1", {31'd0, drop_t1}, 32'd0);
        chk("a_ackv_t1", {31'd0, ackv_t1}, 32'd0);
        settle(4);
        exp_commit++; exp_ack++;
        chk_counts("a");
        chk_last("a", 2'b01, 12'h000);
        chk("a_tl_count", tl_q.size(), 32'd2);
        if (tl_q.size() == 2) begin
            chk("a_tl0", {16'd0, tl_q[0]}, 32'h1234);
            chk("a_tl1", {16'd0, tl_q[1]}, 32'hABCD);
        end

        do_reset();

        // Bad LCRC -> NAK FFF; second bad -> no new NAK
        build(12'h000, 2, 16'h1234, 16'hABCD, 1'b1);
        send_fw(1'b0, 1'b0);
        chk("b_drop_t1", {31'd0, drop_t1}, 32'd1);
        settle(4);
        exp_drop++; exp_ack++;
        chk_counts("b");
        chk_last("b", 2'b10, 12'hFFF);

        build(12'h000, 2, 16'h1234, 16'hABCD, 1'b1);
        send_fw(1'b1, 1'b0);
        settle(4);
        exp_drop++;
        chk_counts("c");

        // Good seq 0 with stalls -> ACK 0
        tl_q.delete();
        build(12'h000, 2, 16'h0F0F, 16'hF0F0, 1'b0);
        send_fw(1'b1, 1'b0);
        settle(4);
        exp_commit++; exp_ack++;
        chk_counts("d");
        chk_last("d", 2'b01, 12'h000);
        chk("d_tl_count", tl_q.size(), 32'd2);
        if (tl_q.size() == 2) begin
            chk("d_tl0", {16'd0, tl_q[0]}, 32'h0F0F);
            chk("d_tl1", {16'd0, tl_q[1]}, 32'hF0F0);
        end

        // seq 1 good, then duplicate seq 1
        build(12'h001, 1, 16'h0001, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_commit++; exp_ack++;
        chk_counts("e");
        chk_last("e", 2'b01, 12'h001);

        build(12'h001, 1, 16'h0001, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        chk("f_drop_t1", {31'd0, drop_t1}, 32'd1);
        settle(4);
        exp_drop++; exp_ack++;
        chk_counts("f");
        chk_last("f", 2'b01, 12'h001);

        for (int s = 2; s <= 4; s++) begin
            build(s[11:0], 1, 16'h5A5A, 16'h0000, 1'b0);
            send_fw(1'b0, 1'b0);
            settle(2);
        end
        exp_commit += 3; exp_ack += 3;
        chk_counts("seq234");
        chk_last("seq234", 2'b01, 12'h004);

        // Lost TLP: expect 5, receive 7
        build(12'h007, 1, 16'h7777, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_drop++; exp_ack++;
        chk_counts("g");
        chk_last("g", 2'b10, 12'h004);

        build(12'h005, 1, 16'h5555, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_commit++; exp_ack++;
        chk_counts("h");
        chk_last("h", 2'b01, 12'h005);

        // Two-word frame is an LCRC failure
        fw.delete();
        fw.push_back(16'h0006);
        fw.push_back(16'h1111);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_drop++; exp_ack++;
        chk_counts("short");
        chk_last("short", 2'b10, 12'h005);

        // Stray rx_eop in IDLE
        rx_valid = 1'b1; rx_eop = 1'b1; rx_data = 16'h9999;
        tick();
        rx_valid = 1'b0; rx_eop = 1'b0;
        settle(4);
        chk_counts("stray_eop");

        // Abort: open frame interrupted by a new good seq 6 frame
        tl_q.delete();
        rx_valid = 1'b1; rx_sop = 1'b1; rx_data = 16'h0006;
        tick();
        rx_sop = 1'b0; rx_data = 16'h2222;
        tick();
        build(12'h006, 1, 16'h3333, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_drop++; exp_commit++; exp_ack++;
        chk_counts("abort");
        chk_last("abort", 2'b01, 12'h006);
        chk("abort_tl_count", tl_q.size(), 32'd1);
        if (tl_q.size() == 1) chk("abort_tl0", {16'd0, tl_q[0]}, 32'h3333);

        // NAK held against a later ACK while ack_ready is low
        ack_ready = 1'b0;
        build(12'h007, 1, 16'h7070, 16'h0000, 1'b1);
        send_fw(1'b0, 1'b0);
        settle(3);
        exp_drop++;
        chk("hold1_valid", {31'd0, ack_valid}, 32'd1);
        chk("hold1_nack", {30'd0, ack_nack}, 32'd2);
        chk("hold1_seq", {20'd0, ack_seq}, 32'h006);
        build(12'h007, 1, 16'h7070, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(3);
        exp_commit++;
        chk("hold2_valid", {31'd0, ack_valid}, 32'd1);
        chk("hold2_nack", {30'd0, ack_nack}, 32'd2);
        chk("hold2_seq", {20'd0, ack_seq}, 32'h006);
        ack_ready = 1'b1;
        tick();
        exp_ack++;
        chk("hold_release_valid", {31'd0, ack_valid}, 32'd0);
        chk("hold_release_nack", {30'd0, ack_nack}, 32'd0);
        chk_counts("hold");
        chk_last("hold", 2'b10, 12'h006);

        // Walk next_rcv_seq up to FFF, then wrap
        for (int s = 8; s <= 12'hFFE; s++) begin
            build(s[11:0], 0, 16'h0000, 16'h0000, 1'b0);
            send_fw(1'b0, 1'b0);
            settle(1);
        end
        exp_commit += 4087; exp_ack += 4087;
        settle(3);
        chk_counts("walk");
        chk_last("walk", 2'b01, 12'hFFE);

        build(12'hFFF, 1, 16'hCAFE, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_commit++; exp_ack++;
        chk_counts("wrap_fff");
        chk_last("wrap_fff", 2'b01, 12'hFFF);

        build(12'h000, 1, 16'hBEEF, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_commit++; exp_ack++;
        chk_counts("wrap_000");
        chk_last("wrap_000", 2'b01, 12'h000);

        // Reset mid-frame with a NAK pending and payload flowing
        ack_ready = 1'b0;
        build(12'h001, 1, 16'h1010, 16'h0000, 1'b1);
        send_fw(1'b0, 1'b0);
        settle(3);
        exp_drop++;
        chk("pre_rst_nack", {30'd0, ack_nack}, 32'd2);
        chk("pre_rst_seq", {20'd0, ack_seq}, 32'h000);
        rx_valid = 1'b1; rx_sop = 1'b1; rx_data = 16'h0001;
        tick();
        rx_sop = 1'b0; rx_data = 16'h4444;
        tick();
        rx_data = 16'h5555;
        tick();
        rx_data = 16'h6666;
        tick();
        chk("pre_rst_tl_valid", {31'd0, tl_valid}, 32'd1);
        chk("pre_rst_tl_data", {16'd0, tl_data}, 32'h4444);
        #1 reset_n = 1'b0;
        #1;
        chk("mid_rst_tl_valid", {31'd0, tl_valid}, 32'd0);
        chk("mid_rst_tl_data", {16'd0, tl_data}, 32'd0);
        chk("mid_rst_commit", {31'd0, tl_commit}, 32'd0);
        chk("mid_rst_drop", {31'd0, tl_drop}, 32'd0);
        chk("mid_rst_ack_valid", {31'd0, ack_valid}, 32'd0);
        chk("mid_rst_ack_nack", {30'd0, ack_nack}, 32'd0);
        chk("mid_rst_ack_seq", {20'd0, ack_seq}, 32'd0);
        rx_valid = 1'b0;
        ack_ready = 1'b1;
        settle(2);
        reset_n = 1'b1;
        settle(4);
        chk_counts("post_rst");

        // Sequence state restarts at 0 after reset
        build(12'h000, 1, 16'h0123, 16'h0000, 1'b0);
        send_fw(1'b0, 1'b0);
        settle(4);
        exp_commit++; exp_ack++;
        chk_counts("post_rst_seq0");
        chk_last("post_rst_seq0", 2'b01, 12'h000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
